// File: rtl/prio_enc_hs_if.sv
// Valid/ready bundle for prio_enc_hs.
// The request side is i/in_valid/in_ready; the result side is y/any/multi/out_valid/out_ready.
interface prio_enc_hs_if #(
    parameter int N = 8
);
    localparam int W = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0] i;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] y;
    logic         any;
    logic         multi;
    logic         out_valid;
    logic         out_ready;

    modport master (
        output i, in_valid, out_ready,
        input  in_ready, y, any, multi, out_valid
    );

    modport slave (
        input  i, in_valid, out_ready,
        output in_ready, y, any, multi, out_valid
    );
endinterface

// File: rtl/prio_enc_hs.sv
// Registered N-input priority encoder with valid/ready on both sides, one result per cycle.
// Define PRIO_ENC_HS_ROUND_ROBIN_EN to rotate the search start past the last winner.
module prio_enc_hs #(
    parameter int N = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enb,
    prio_enc_hs_if.slave  bus
);
    localparam int W = (N > 1) ? $clog2(N) : 1;

    logic         valid_q;
    logic [W-1:0] y_q;
    logic         any_q;
    logic         multi_q;

    logic         ready;
    logic         accept;
    logic [W-1:0] idx_nxt;
    logic [W-1:0] k;
    logic         hit;
    logic         any_nxt;
    logic         multi_nxt;

    // Output register may be refilled in the same cycle it is drained.
    assign ready  = enb && (!valid_q || bus.out_ready);
    assign accept = bus.in_valid && ready;

    assign any_nxt   = |bus.i;
    // Clearing the lowest set bit leaves something only when two or more were set.
    assign multi_nxt = |(bus.i & (bus.i - N'(1)));

`ifdef PRIO_ENC_HS_ROUND_ROBIN_EN
    logic [W-1:0] ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (accept && any_nxt) begin
            ptr <= (idx_nxt == W'(N - 1)) ? '0 : idx_nxt + 1'b1;
        end
    end
`endif

    always_comb begin
        idx_nxt = '0;
        hit     = 1'b0;
        k       = '0;
        for (int off = 0; off < N; off++) begin
`ifdef PRIO_ENC_HS_ROUND_ROBIN_EN
            k = W'((int'(ptr) + off) % N);
`else
            k = W'(off);
`endif
            if (!hit && bus.i[k]) begin
                hit     = 1'b1;
                idx_nxt = k;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            y_q     <= '0;
            any_q   <= 1'b0;
            multi_q <= 1'b0;
        end else if (accept) begin
            valid_q <= 1'b1;
            y_q     <= idx_nxt;
            any_q   <= any_nxt;
            multi_q <= multi_nxt;
        end else if (bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = valid_q;
    assign bus.y         = y_q;
    assign bus.any       = any_q;
    assign bus.multi     = multi_q;
endmodule

// File: tb/tb_prio_enc_hs.sv
// Bench for prio_enc_hs: N=8 and N=5 instances driven in lockstep, checked every cycle against a
// rotate-and-isolate-lowest-bit model, plus literal expectations at key points.
module tb_prio_enc_hs;
`ifdef PRIO_ENC_HS_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enb = 1'b1;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic [7:0] i8 = '0;
    logic [4:0] i5 = '0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    prio_enc_hs_if #(.N(8)) b8 ();
    prio_enc_hs_if #(.N(5)) b5 ();

    assign b8.i = i8;
    assign b5.i = i5;
    assign b8.in_valid  = in_valid;
    assign b5.in_valid  = in_valid;
    assign b8.out_ready = out_ready;
    assign b5.out_ready = out_ready;

    prio_enc_hs #(.N(8)) dut8 (.clk(clk), .rst_n(rst_n), .enb(enb), .bus(b8));
    prio_enc_hs #(.N(5)) dut5 (.clk(clk), .rst_n(rst_n), .enb(enb), .bus(b5));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Winner = lowest set bit of the vector rotated right by the start position.
    function automatic int mdl_idx(input logic [63:0] v, input int n, input int p);
        logic [63:0] mask, rot, low;
        mask = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
        rot  = ((v >> p) | (v << (n - p))) & mask;
        if (rot == 0) return 0;
        low = rot & (~rot + 64'd1);
        return ($clog2(low) + p) % n;
    endfunction

    int          m_n[2] = '{8, 5};
    logic        m_valid[2];
    int          m_y[2];
    int          m_ptr[2];
    logic        m_any[2];
    logic        m_multi[2];
    logic [63:0] m_v;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                m_valid[d] = 1'b0; m_y[d] = 0; m_ptr[d] = 0; m_any[d] = 1'b0; m_multi[d] = 1'b0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                m_v = (d == 0) ? 64'(i8) : 64'(i5);
                if (in_valid && enb && (!m_valid[d] || out_ready)) begin
                    m_valid[d] = 1'b1;
                    m_y[d]     = mdl_idx(m_v, m_n[d], RR ? m_ptr[d] : 0);
                    m_any[d]   = (m_v != 0);
                    m_multi[d] = ($countones(m_v) > 1);
                    if (RR && m_any[d]) m_ptr[d] = (m_y[d] + 1) % m_n[d];
                end else if (out_ready) begin
                    m_valid[d] = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("m8_valid", 32'(b8.out_valid), 32'(m_valid[0]));
            check("m8_y",     32'(b8.y),         m_y[0]);
            check("m8_any",   32'(b8.any),       32'(m_any[0]));
            check("m8_multi", 32'(b8.multi),     32'(m_multi[0]));
            check("m8_ready", 32'(b8.in_ready),  32'(enb && (!m_valid[0] || out_ready)));
            check("m5_valid", 32'(b5.out_valid), 32'(m_valid[1]));
            check("m5_y",     32'(b5.y),         m_y[1]);
            check("m5_any",   32'(b5.any),       32'(m_any[1]));
            check("m5_multi", 32'(b5.multi),     32'(m_multi[1]));
            check("m5_ready", 32'(b5.in_ready),  32'(enb && (!m_valid[1] || out_ready)));
            check("m5_y_range", 32'(b5.y <= 3'd4), 1);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    logic [7:0] stall_v[5] = '{8'hFF, 8'h80, 8'h03, 8'h10, 8'h00};
    logic [7:0] rr8[6]     = '{8'h05, 8'h05, 8'h05, 8'h05, 8'h80, 8'h81};
    logic [4:0] rr5[6]     = '{5'h11, 5'h11, 5'h11, 5'h11, 5'h00, 5'h01};
    int         rr_y8[6]   = '{0, 2, 0, 2, 7, 0};
    int         rr_y5[6]   = '{0, 4, 0, 4, 0, 0};
    int         fx_y8[6]   = '{0, 0, 0, 0, 7, 0};
    int         fx_y5[6]   = '{0, 0, 0, 0, 0, 0};

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(b8.out_valid), 0);
        check("rst_y",     32'(b8.y), 0);
        check("rst_any",   32'(b8.any), 0);
        check("rst_multi", 32'(b8.multi), 0);
        cyc();
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_in_ready", 32'(b8.in_ready), 1);
        check("idle_valid",    32'(b8.out_valid), 0);

        for (int k = 0; k < 8; k++) begin
            cyc();
            i8 = 8'd1 << k; i5 = i8[4:0]; in_valid = 1'b1;
            @(negedge clk);
            if (k > 0) begin
                check("sweep_y",     32'(b8.y), k - 1);
                check("sweep_valid", 32'(b8.out_valid), 1);
                check("sweep_multi", 32'(b8.multi), 0);
            end
        end
        cyc();
        in_valid = 1'b0; i8 = '0; i5 = '0;
        @(negedge clk);
        check("sweep_last_y", 32'(b8.y), 7);

        cyc();
        i8 = 8'hA0; i5 = i8[4:0]; in_valid = 1'b1;
        cyc();
        i8 = '0; i5 = '0;
        @(negedge clk);
        check("multi_y",     32'(b8.y), 5);
        check("multi_any",   32'(b8.any), 1);
        check("multi_multi", 32'(b8.multi), 1);
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
        check("empty_y",     32'(b8.y), 0);
        check("empty_any",   32'(b8.any), 0);
        check("empty_multi", 32'(b8.multi), 0);
        check("empty_valid", 32'(b8.out_valid), 1);

        cyc();
        out_ready = 1'b0; i8 = 8'h0C; i5 = i8[4:0]; in_valid = 1'b1;
        cyc();
        for (int c = 0; c < 5; c++) begin
            i8 = stall_v[c]; i5 = i8[4:0];
            @(negedge clk);
            check("stall_y",     32'(b8.y), 2);
            check("stall_ready", 32'(b8.in_ready), 0);
            check("stall_valid", 32'(b8.out_valid), 1);
            cyc();
        end
        out_ready = 1'b1; i8 = 8'h40; i5 = i8[4:0];
        #1;
        check("release_ready", 32'(b8.in_ready), 1);
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
        check("release_y", 32'(b8.y), 6);

        cyc();
        enb = 1'b0; out_ready = 1'b0; in_valid = 1'b1; i8 = 8'h01; i5 = 5'h01;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("enb_valid", 32'(b8.out_valid), 0);
            check("enb_ready", 32'(b8.in_ready), 0);
            cyc();
        end
        enb = 1'b1;
        cyc();
        @(negedge clk);
        check("enb_on_y",     32'(b8.y), 0);
        check("enb_on_valid", 32'(b8.out_valid), 1);
        check("enb_on_ready", 32'(b8.in_ready), 0);

        cyc();
        #1 rst_n = 1'b0;
        #1;
        check("arst_valid8", 32'(b8.out_valid), 0);
        check("arst_valid5", 32'(b5.out_valid), 0);
        check("arst_y8",     32'(b8.y), 0);
        cyc();
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1; i8 = '0; i5 = '0;

        for (int k = 0; k < 6; k++) begin
            cyc();
            i8 = rr8[k]; i5 = rr5[k]; in_valid = 1'b1;
            @(negedge clk);
            if (k > 0) begin
                check("seq_y8", 32'(b8.y), RR ? rr_y8[k - 1] : fx_y8[k - 1]);
                check("seq_y5", 32'(b5.y), RR ? rr_y5[k - 1] : fx_y5[k - 1]);
            end
        end
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
        check("seq_last_y8", 32'(b8.y), RR ? rr_y8[5] : fx_y8[5]);
        check("seq_last_y5", 32'(b5.y), RR ? rr_y5[5] : fx_y5[5]);

        repeat (3) cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/prio_enc_hs.md
Name: prio_enc_hs

Overview:
- Parametrised, registered N-input priority encoder with valid/ready handshake on both sides.
- Generalises the fixed 8:3 one-hot encoder:
  - any input pattern is legal, not only one-hot;
  - result is registered;
  - flags report whether any bit was set and whether more than one bit was set.
- Sits between request sources (interrupt/request vectors) and downstream index consumers (mux selects, arbiter grants).

Parameters:
- N, 8, number of request inputs; legal range 1..64.
- W, $clog2(N) (minimum 1), output index width; derived, not overridden by users.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- enb  input  1  block enable; low blocks new acceptances
- i  input  N  request vector, bit k = request k
- in_valid  input  1  i is valid this cycle
- in_ready  output  1  block can accept i this cycle
- y  output  W  encoded index of winning request
- any  output  1  at least one bit of the accepted vector was set
- multi  output  1  more than one bit of the accepted vector was set
- out_valid  output  1  y/any/multi hold a result
- out_ready  input  1  downstream consumes result this cycle

Behaviour:
- Reset (rst_n low, asynchronous, effective immediately):
  - out_valid=0, y=0, any=0, multi=0;
  - round-robin pointer (if compiled in) = 0.
- in_ready = enb && (!out_valid || out_ready). This is combinational; there is no path from in_valid to in_ready.
- Accept: in_valid && in_ready on a clock edge.
  - Next cycle: out_valid=1, with y/any/multi computed from the accepted i.
  - Latency: exactly 1 cycle.
- Fixed priority: the lowest set index wins. Example: i=8'b0010_0100 gives y=2.
- Empty vector: i=0 gives y=0, any=0, multi=0, out_valid=1. The result is still delivered so the downstream sees the empty response.
- multi = popcount(i) > 1.
- Consume: out_valid && out_ready on a clock edge.
  - With no simultaneous accept: out_valid falls to 0 next cycle.
  - y/any/multi keep their last value while out_valid=0.
- Simultaneous consume and accept: the result register is replaced by the new result and out_valid stays 1. This gives full throughput of 1 result per cycle.
- Stall: while out_valid && !out_ready, y/any/multi/out_valid are held stable and in_ready=0.
- enb low:
  - in_ready=0 and no acceptance occurs;
  - a pending result is still presented and may still be consumed;
  - the enb low/high transition has no other effect.
- Reset mid-operation: any pending result is discarded; out_valid=0 immediately and asynchronously.
- N not a power of two: y never exceeds N-1.
- N=1: W=1, y is always 0, multi is always 0.
- Any input pattern produces defined outputs; no X propagation, no latches.

Optional Feature:
- Macro: PRIO_ENC_HS_ROUND_ROBIN_EN.
- Defined:
  - Adds an internal pointer register ptr (W bits, reset 0).
  - Search begins at index ptr, ascending with wrap from N-1 to 0; the first set bit wins.
  - On each accept with any=1, ptr updates to (y_new+1) mod N.
  - On accept with i=0, ptr is unchanged.
  - ptr is unchanged while stalled or while enb is low.
  - Flags any/multi are unaffected by the feature.
- Not defined: fixed lowest-index-first priority as above; no pointer register exists.

Test Plan:
- Reset then idle (N=8): hold rst_n=0 for 3 cycles, then release -> out_valid=0, y=0, any=0, multi=0, in_ready=1 with enb=1.
- One-hot sweep (N=8, out_ready=1, enb=1): i=1<<k for k=0..7, one vector per cycle back-to-back -> y=k one cycle after each, any=1, multi=0, out_valid stays 1 for 8 consecutive cycles.
- Multi-hot and empty vectors:
  - i=8'b1010_0000 -> y=5, any=1, multi=1;
  - i=0 -> y=0, any=0, multi=0, out_valid=1.
- Backpressure and enable:
  - out_ready=0 after one accept -> in_ready=0, and y held for 5 cycles despite changing i; raise out_ready -> the next vector is accepted in the same cycle;
  - enb=0 with in_valid=1 -> no accept and out_valid unchanged.
- Asynchronous reset mid-stall: pulse rst_n low between clock edges while out_valid=1 -> out_valid=0 before the next edge.
- Round-robin (macro defined, N=8), repeated i=8'b0000_0101 -> y sequence 0,2,0,2.
  - Then i=8'b1000_0000 -> y=7, ptr wraps to 0, and the next i=8'b1000_0001 -> y=0.
  - Also run with N=5: i=5'b10001 repeated -> y sequence 0,4,0.
